// File: rtl/add_sub_checker_if.sv
// Bundle between an add_sub stimulus source and its response checker.
// master drives vectors and session control; slave is the checker.
interface add_sub_checker_if #(
    parameter int n     = 4,
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] num_vec;
    logic             in_valid;
    logic [n-1:0]     a;
    logic [n-1:0]     b;
    logic             ctr;
    logic [n-1:0]     s;
    logic             cout;

    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] vec_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             fail_vld;
    logic [n-1:0]     fail_a;
    logic [n-1:0]     fail_b;
    logic             fail_ctr;
    logic [n-1:0]     fail_s;
    logic             fail_cout;

    modport master (
        output start, num_vec, in_valid, a, b, ctr, s, cout,
        input  busy, done, pass, vec_cnt, err_cnt,
               fail_vld, fail_a, fail_b, fail_ctr, fail_s, fail_cout
    );

    modport slave (
        input  start, num_vec, in_valid, a, b, ctr, s, cout,
        output busy, done, pass, vec_cnt, err_cnt,
               fail_vld, fail_a, fail_b, fail_ctr, fail_s, fail_cout
    );
endinterface

// File: rtl/add_sub_checker.sv
// Response checker for an n-bit add/subtract unit: compares each strobed result
// against a golden sum, counts vectors/errors and captures the first failure.
module add_sub_checker #(
    parameter int n     = 4,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    add_sub_checker_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] nv_q;
    logic [CNT_W-1:0] vec_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             fail_vld;
    logic [n-1:0]     fail_a;
    logic [n-1:0]     fail_b;
    logic             fail_ctr;
    logic [n-1:0]     fail_s;
    logic             fail_cout;

    logic [n:0]       exp_sum;
    logic             mismatch;
    logic [CNT_W-1:0] vec_nxt;

    // Subtract is a + ~b + 1 so the carry out doubles as the a>=b flag.
    always_comb begin
        if (bus.ctr)
            exp_sum = {1'b0, bus.a} + {1'b0, ~bus.b} + (n+1)'(1);
        else
            exp_sum = {1'b0, bus.a} + {1'b0, bus.b};
    end

    assign mismatch = ({bus.cout, bus.s} != exp_sum);
    assign vec_nxt  = vec_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            nv_q      <= '0;
            vec_cnt   <= '0;
            err_cnt   <= '0;
            fail_vld  <= 1'b0;
            fail_a    <= '0;
            fail_b    <= '0;
            fail_ctr  <= 1'b0;
            fail_s    <= '0;
            fail_cout <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    // An empty session closes on the first RUN edge without sampling.
                    if (nv_q == '0) begin
                        state <= DONE;
                    end else if (bus.in_valid) begin
                        vec_cnt <= vec_nxt;
                        if (mismatch) begin
                            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                            if (!fail_vld) begin
                                fail_vld  <= 1'b1;
                                fail_a    <= bus.a;
                                fail_b    <= bus.b;
                                fail_ctr  <= bus.ctr;
                                fail_s    <= bus.s;
                                fail_cout <= bus.cout;
                            end
                        end
                        if (vec_nxt == nv_q) state <= DONE;
                    end
                end
                default: begin
                    if (bus.start) begin
                        state     <= RUN;
                        nv_q      <= bus.num_vec;
                        vec_cnt   <= '0;
                        err_cnt   <= '0;
                        fail_vld  <= 1'b0;
                        fail_a    <= '0;
                        fail_b    <= '0;
                        fail_ctr  <= 1'b0;
                        fail_s    <= '0;
                        fail_cout <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.busy      = (state == RUN);
    assign bus.done      = (state == DONE);
    assign bus.pass      = (state == DONE) && (err_cnt == '0);
    assign bus.vec_cnt   = vec_cnt;
    assign bus.err_cnt   = err_cnt;
    assign bus.fail_vld  = fail_vld;
    assign bus.fail_a    = fail_a;
    assign bus.fail_b    = fail_b;
    assign bus.fail_ctr  = fail_ctr;
    assign bus.fail_s    = fail_s;
    assign bus.fail_cout = fail_cout;
endmodule

// File: tb/tb_add_sub_checker.sv
// Directed and random session bench for add_sub_checker with a transaction-level
// reference model; every output is compared after every clock.
module tb_add_sub_checker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    add_sub_checker_if #(.n(4), .CNT_W(8)) ifc ();
    add_sub_checker #(.n(4), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

    int errors = 0;
    int checks = 0;

    // reference model: 0 idle, 1 running, 2 finished
    int m_state, m_num, m_vec, m_err, m_fvld, m_fa, m_fb, m_fc, m_fs, m_fco;

    function automatic int gold(input int av, input int bv, input int c);
        int r, co;
        r  = c ? av - bv : av + bv;
        co = c ? int'(av >= bv) : int'(r > 15);
        return (co << 4) | (r & 15);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_num = 0; m_vec = 0; m_err = 0; m_fvld = 0;
        m_fa = 0; m_fb = 0; m_fc = 0; m_fs = 0; m_fco = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".busy"},      32'(ifc.busy),      32'(m_state == 1));
        chk({tag, ".done"},      32'(ifc.done),      32'(m_state == 2));
        chk({tag, ".pass"},      32'(ifc.pass),      32'(m_state == 2 && m_err == 0));
        chk({tag, ".vec_cnt"},   32'(ifc.vec_cnt),   32'(m_vec));
        chk({tag, ".err_cnt"},   32'(ifc.err_cnt),   32'(m_err));
        chk({tag, ".fail_vld"},  32'(ifc.fail_vld),  32'(m_fvld));
        chk({tag, ".fail_a"},    32'(ifc.fail_a),    32'(m_fa));
        chk({tag, ".fail_b"},    32'(ifc.fail_b),    32'(m_fb));
        chk({tag, ".fail_ctr"},  32'(ifc.fail_ctr),  32'(m_fc));
        chk({tag, ".fail_s"},    32'(ifc.fail_s),    32'(m_fs));
        chk({tag, ".fail_cout"}, 32'(ifc.fail_cout), 32'(m_fco));
    endtask

    task automatic model_edge(input int st, input int nv, input int iv, input int av,
                              input int bv, input int c, input int sv, input int co);
        int g;
        if (m_state != 1) begin
            if (st != 0) begin
                model_reset();
                m_state = 1;
                m_num   = nv;
            end
        end else if (m_num == 0) begin
            m_state = 2;
        end else if (iv != 0) begin
            m_vec++;
            g = gold(av, bv, c);
            if (sv != (g & 15) || co != (g >> 4)) begin
                if (m_err < 255) m_err++;
                if (m_fvld == 0) begin
                    m_fvld = 1; m_fa = av; m_fb = bv; m_fc = c; m_fs = sv; m_fco = co;
                end
            end
            if (m_vec == m_num) m_state = 2;
        end
    endtask

    // Called at a negedge: drive, let one posedge pass, then compare at the next negedge.
    task automatic cyc(input string tag, input int st, input int nv, input int iv,
                       input int av, input int bv, input int c, input int sv, input int co);
        ifc.start    = (st != 0);
        ifc.num_vec  = nv[7:0];
        ifc.in_valid = (iv != 0);
        ifc.a        = av[3:0];
        ifc.b        = bv[3:0];
        ifc.ctr      = c[0];
        ifc.s        = sv[3:0];
        ifc.cout     = co[0];
        @(negedge clk);
        model_edge(st, nv, iv, av, bv, c, sv, co);
        check_all(tag);
    endtask

    task automatic start_s(input string tag, input int nv);
        cyc(tag, 1, nv, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic good_vec(input string tag, input int av, input int bv, input int c);
        int g;
        g = gold(av, bv, c);
        cyc(tag, 0, 0, 1, av, bv, c, g & 15, g >> 4);
    endtask

    int va [5] = '{1, 9, 5, 15, 15};
    int vb [5] = '{2, 6, 11, 1, 15};
    int add_s [5] = '{3, 15, 0, 0, 14};
    int add_c [5] = '{0, 0, 1, 1, 1};
    int sub_s [5] = '{15, 3, 10, 14, 0};
    int sub_c [5] = '{0, 1, 0, 1, 1};

    initial begin
        int ra, rb, rc, g, sv, co;
        model_reset();
        ifc.start = 1'b0; ifc.num_vec = '0; ifc.in_valid = 1'b0;
        ifc.a = '0; ifc.b = '0; ifc.ctr = 1'b0; ifc.s = '0; ifc.cout = 1'b0;
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all("idle");

        // 1: additions from the fixed table
        start_s("t1.start", 5);
        for (int i = 0; i < 5; i++) cyc("t1.vec", 0, 0, 1, va[i], vb[i], 0, add_s[i], add_c[i]);
        chk("t1.done", 32'(ifc.done), 1);
        chk("t1.vec_cnt", 32'(ifc.vec_cnt), 5);
        chk("t1.pass", 32'(ifc.pass), 1);

        // 2: subtractions from the fixed table, restarted from DONE
        start_s("t2.start", 5);
        for (int i = 0; i < 5; i++) cyc("t2.vec", 0, 0, 1, va[i], vb[i], 1, sub_s[i], sub_c[i]);
        chk("t2.err_cnt", 32'(ifc.err_cnt), 0);
        chk("t2.pass", 32'(ifc.pass), 1);

        // 3: corrupted s on vector 2, corrupted cout on vector 4
        start_s("t3.start", 5);
        for (int i = 0; i < 5; i++)
            cyc("t3.vec", 0, 0, 1, va[i], vb[i], 0, (i == 1) ? 4 : add_s[i],
                (i == 3) ? 0 : add_c[i]);
        chk("t3.err_cnt", 32'(ifc.err_cnt), 2);
        chk("t3.pass", 32'(ifc.pass), 0);
        chk("t3.fail_a", 32'(ifc.fail_a), 9);
        chk("t3.fail_b", 32'(ifc.fail_b), 6);
        chk("t3.fail_s", 32'(ifc.fail_s), 4);
        chk("t3.fail_vld", 32'(ifc.fail_vld), 1);

        // 4: empty session, then gaps and stray starts inside RUN
        start_s("t4.start0", 0);
        chk("t4.busy0", 32'(ifc.busy), 1);
        cyc("t4.idle", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t4.done0", 32'(ifc.done), 1);
        chk("t4.pass0", 32'(ifc.pass), 1);
        start_s("t4.start3", 3);
        good_vec("t4.v1", 3, 4, 0);
        cyc("t4.gap", 0, 0, 0, 7, 7, 0, 1, 1);
        cyc("t4.stray", 1, 9, 1, 12, 5, 1, 7, 1);
        cyc("t4.stray_only", 1, 9, 0, 0, 0, 0, 0, 0);
        good_vec("t4.v3", 2, 9, 1);
        chk("t4.vec_cnt", 32'(ifc.vec_cnt), 3);
        chk("t4.done3", 32'(ifc.done), 1);
        cyc("t4.frozen", 0, 0, 1, 1, 1, 0, 0, 0);

        // random mix of good and corrupted vectors
        start_s("rnd.start", 40);
        for (int i = 0; i < 40; i++) begin
            ra = int'($urandom_range(0, 15));
            rb = int'($urandom_range(0, 15));
            rc = int'($urandom_range(0, 1));
            g  = gold(ra, rb, rc);
            sv = g & 15;
            co = g >> 4;
            case ($urandom_range(0, 3))
                0: sv = sv ^ int'($urandom_range(1, 15));
                1: co = co ^ 1;
                default: ;
            endcase
            if ($urandom_range(0, 4) == 0) cyc("rnd.gap", 0, 0, 0, ra, rb, rc, sv, co);
            cyc("rnd.vec", 0, 0, 1, ra, rb, rc, sv, co);
        end

        // 5: asynchronous reset in the middle of a session
        start_s("t5.start", 5);
        for (int i = 0; i < 3; i++) good_vec("t5.vec", i, 15 - i, i & 1);
        ifc.in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t5.async");
        chk("t5.vec_cnt0", 32'(ifc.vec_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        start_s("t5.restart", 2);
        good_vec("t5.v1", 8, 8, 1);
        good_vec("t5.v2", 8, 8, 0);
        chk("t5.pass", 32'(ifc.pass), 1);

        // 6: every vector fails, then a restart from DONE
        start_s("t6.start", 255);
        for (int i = 0; i < 255; i++) begin
            ra = i & 15;
            rb = (i >> 4) & 15;
            g  = gold(ra, rb, i & 1);
            cyc("t6.vec", 0, 0, 1, ra, rb, i & 1, (g & 15) ^ 1, g >> 4);
        end
        chk("t6.err_cnt", 32'(ifc.err_cnt), 255);
        chk("t6.pass", 32'(ifc.pass), 0);
        chk("t6.done", 32'(ifc.done), 1);
        start_s("t6.restart", 2);
        chk("t6.clr_err", 32'(ifc.err_cnt), 0);
        chk("t6.clr_fvld", 32'(ifc.fail_vld), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
